edge_row_cache: RTL and testbench

Parametrised, row-granular edge cache for the Dijkstra datapath. It holds up to MAX_NODES adjacency-matrix rows, each MAX_NODES × VALUE_WIDTH, in a single inferred block RAM, and tracks a valid bit per row. A miss on a lookup of edge (from, to) triggers a streamed fill of the whole `from` row from the graph source; the lookup is then answered from the cache. A flush invalidates every row between graph loads.

---
 rtl/edge_row_cache.sv | 171 +++++++++++++++++
 tb/tb_edge_row_cache.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/edge_row_cache.sv
// Row-granular adjacency-matrix edge cache: a miss streams the whole source row
// into a single-port block RAM, then the lookup is answered from the RAM.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 3
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif

module edge_row_cache #(
    parameter int unsigned MAX_NODES   = `DEFAULT_MAX_NODES,
    parameter int unsigned INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
    parameter int unsigned VALUE_WIDTH = `DEFAULT_VALUE_WIDTH,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rd_valid,
    output logic                   rd_ready,
    input  logic [INDEX_WIDTH-1:0] rd_from,
    input  logic [INDEX_WIDTH-1:0] rd_to,
    output logic                   resp_valid,
    output logic [VALUE_WIDTH-1:0] resp_value,
    output logic                   resp_error,
    output logic                   fill_req,
    output logic [INDEX_WIDTH-1:0] fill_row,
    input  logic                   fill_valid,
    input  logic [VALUE_WIDTH-1:0] fill_data,
    input  logic                   flush,
    output logic [COUNT_WIDTH-1:0] hit_count,
    output logic [COUNT_WIDTH-1:0] miss_count
);

    localparam int unsigned DEPTH  = MAX_NODES * MAX_NODES;
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, READ, RESP, FILL} state_t;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] from_q, from_d, to_q, to_d, col_q, col_d;
    logic [MAX_NODES-1:0]   valid_q, valid_d, valid_shift_c;
    logic                   pend_q, pend_d, rdy_q;
    logic                   resp_valid_d, resp_error_d, fill_req_d;
    logic [VALUE_WIDTH-1:0] resp_value_d;
    logic [INDEX_WIDTH-1:0] fill_row_d;
    logic [COUNT_WIDTH-1:0] hit_d, miss_d;
    logic                   oor_in_c, oor_q_c, ram_we_c;
    logic [ADDR_W-1:0]      ram_addr_c, rd_addr_c, fill_addr_c;
    logic [VALUE_WIDTH-1:0] mem [DEPTH];
    logic [VALUE_WIDTH-1:0] ram_q;

    // A flush (live or pending) owns the IDLE cycle, so no request is taken then
    assign rd_ready = rdy_q && !flush && !pend_q;

    assign oor_in_c      = (32'(rd_from) >= MAX_NODES) || (32'(rd_to) >= MAX_NODES);
    assign oor_q_c       = (32'(from_q) >= MAX_NODES) || (32'(to_q) >= MAX_NODES);
    assign valid_shift_c = valid_q >> rd_from;
    assign rd_addr_c     = ADDR_W'(32'(from_q) * MAX_NODES + 32'(to_q));
    assign fill_addr_c   = ADDR_W'(32'(from_q) * MAX_NODES + 32'(col_q));

    // Single-port RAM, registered read; contents are deliberately not reset
    always_ff @(posedge clock) begin
        if (ram_we_c) begin
            mem[ram_addr_c] <= fill_data;
        end
        ram_q <= mem[ram_addr_c];
    end

    always_comb begin
        state_d      = state_q;
        from_d       = from_q;
        to_d         = to_q;
        col_d        = col_q;
        valid_d      = valid_q;
        pend_d       = pend_q;
        hit_d        = hit_count;
        miss_d       = miss_count;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        resp_value_d = resp_value;
        ram_we_c     = 1'b0;
        ram_addr_c   = rd_addr_c;

        case (state_q)
            IDLE: begin
                if (flush || pend_q) begin
                    valid_d = '0;
                    pend_d  = 1'b0;
                end else if (rd_valid) begin
                    from_d = rd_from;
                    to_d   = rd_to;
                    if (oor_in_c) begin
                        state_d = RESP;
                    end else if (valid_shift_c[0]) begin
                        state_d = READ;
                        hit_d   = (hit_count == '1) ? hit_count : hit_count + COUNT_WIDTH'(1);
                    end else begin
                        state_d = FILL;
                        col_d   = '0;
                        miss_d  = (miss_count == '1) ? miss_count : miss_count + COUNT_WIDTH'(1);
                    end
                end
            end
            READ: state_d = RESP;
            RESP: begin
                resp_valid_d = 1'b1;
                resp_error_d = oor_q_c;
                resp_value_d = oor_q_c ? '1 : ram_q;
                state_d      = IDLE;
            end
            FILL: begin
                ram_addr_c = fill_addr_c;
                if (fill_valid) begin
                    ram_we_c = 1'b1;
                    col_d    = col_q + INDEX_WIDTH'(1);
                    if (col_q == INDEX_WIDTH'(MAX_NODES - 1)) begin
                        valid_d = valid_q | (MAX_NODES'(1) << from_q);
                        state_d = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush arriving while busy is deferred to the next IDLE cycle
        if (flush && state_q != IDLE) begin
            pend_d = 1'b1;
        end

        fill_req_d = (state_d == FILL);
        fill_row_d = (state_d == FILL) ? from_d : fill_row;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            from_q     <= '0;
            to_q       <= '0;
            col_q      <= '0;
            valid_q    <= '0;
            pend_q     <= 1'b0;
            rdy_q      <= 1'b1;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_value <= '0;
            fill_req   <= 1'b0;
            fill_row   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state_q    <= state_d;
            from_q     <= from_d;
            to_q       <= to_d;
            col_q      <= col_d;
            valid_q    <= valid_d;
            pend_q     <= pend_d;
            rdy_q      <= (state_d == IDLE);
            resp_valid <= resp_valid_d;
            resp_error <= resp_error_d;
            resp_value <= resp_value_d;
            fill_req   <= fill_req_d;
            fill_row   <= fill_row_d;
            hit_count  <= hit_d;
            miss_count <= miss_d;
        end
    end

endmodule

// File: tb/tb_edge_row_cache.sv
// Directed bench for edge_row_cache: 4-node graph, 8-bit weights, 2-bit counters.
module tb_edge_row_cache;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 3;
    localparam int unsigned VW = 8;
    localparam int unsigned CW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          rd_valid, rd_ready;
    logic [IW-1:0] rd_from, rd_to;
    logic          resp_valid, resp_error;
    logic [VW-1:0] resp_value;
    logic          fill_req;
    logic [IW-1:0] fill_row;
    logic          fill_valid;
    logic [VW-1:0] fill_data;
    logic          flush;
    logic [CW-1:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    edge_row_cache #(
        .MAX_NODES(N), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW), .COUNT_WIDTH(CW)
    ) dut (
        .clock(clock), .reset(reset),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_from(rd_from), .rd_to(rd_to),
        .resp_valid(resp_valid), .resp_value(resp_value), .resp_error(resp_error),
        .fill_req(fill_req), .fill_row(fill_row), .fill_valid(fill_valid), .fill_data(fill_data),
        .flush(flush), .hit_count(hit_count), .miss_count(miss_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rd_ready"},   32'(rd_ready),   1);
        check({tag, "_resp_valid"}, 32'(resp_valid), 0);
        check({tag, "_resp_error"}, 32'(resp_error), 0);
        check({tag, "_resp_value"}, 32'(resp_value), 0);
        check({tag, "_fill_req"},   32'(fill_req),   0);
        check({tag, "_fill_row"},   32'(fill_row),   0);
        check({tag, "_hit"},        32'(hit_count),  0);
        check({tag, "_miss"},       32'(miss_count), 0);
    endtask

    // One lookup: feeds the fill stream (with optional stall/flush) and measures the response
    task automatic lookup(input int f, input int t, input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input logic [7:0] w3, input int stall_at,
                          input int stall_len, input int flush_at, output int lat,
                          output logic [7:0] val, output logic err, output int fcyc, output int frow);
        logic [7:0] words [4];
        int wi, sl, k;
        bit got;
        words = '{w0, w1, w2, w3};
        wi = 0; sl = stall_len; fcyc = 0; frow = -1; got = 1'b0; lat = -1; val = '0; err = 1'b0;
        for (int i = 0; i < 20 && !rd_ready; i++) @(negedge clock);
        rd_valid = 1'b1; rd_from = IW'(f); rd_to = IW'(t);
        @(negedge clock);
        rd_valid = 1'b0;
        check("busy_rd_ready", 32'(rd_ready), 0);
        k = 0;
        while (!got && k < 40) begin
            flush = (k == flush_at);
            if (resp_valid) begin
                got = 1'b1; lat = k; val = resp_value; err = resp_error;
            end
            if (fill_req) begin
                fcyc++; frow = int'(fill_row);
                if (wi == stall_at && sl > 0) begin
                    fill_valid = 1'b0; sl--;
                end else if (wi < 4) begin
                    fill_valid = 1'b1; fill_data = words[wi]; wi++;
                end else begin
                    fill_valid = 1'b0;
                end
            end else begin
                fill_valid = 1'b0;
            end
            if (!got) begin
                @(negedge clock);
                k++;
            end
        end
        fill_valid = 1'b0;
        flush = 1'b0;
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL resp_timeout: observed=no response after %0d cycles expected=response", k);
        end
        @(negedge clock);
        check("resp_pulse_width", 32'(resp_valid), 0);
    endtask

    task automatic expect_lookup(input string tag, input int f, input int t,
                                 input logic [7:0] w0, input logic [7:0] w1,
                                 input logic [7:0] w2, input logic [7:0] w3,
                                 input int stall_at, input int stall_len, input int flush_at,
                                 input int e_lat, input int e_val, input int e_err,
                                 input int e_fcyc, input int e_frow, input int e_hit, input int e_miss);
        int lat, fcyc, frow;
        logic [7:0] val;
        logic err;
        lookup(f, t, w0, w1, w2, w3, stall_at, stall_len, flush_at, lat, val, err, fcyc, frow);
        check({tag, "_latency"},  32'(lat),        32'(e_lat));
        check({tag, "_value"},    32'(val),        32'(e_val));
        check({tag, "_error"},    32'(err),        32'(e_err));
        check({tag, "_fill_cyc"}, 32'(fcyc),       32'(e_fcyc));
        check({tag, "_fill_row"}, 32'(frow),       32'(e_frow));
        check({tag, "_hit"},      32'(hit_count),  32'(e_hit));
        check({tag, "_miss"},     32'(miss_count), 32'(e_miss));
    endtask

    initial begin
        reset = 1'b1; rd_valid = 1'b0; rd_from = '0; rd_to = '0;
        fill_valid = 1'b0; fill_data = '0; flush = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check_reset_state("reset");

        // Cold miss on row 1, then hits served from the filled row
        expect_lookup("cold_miss", 1, 2, 8'd10, 8'd11, 8'd12, 8'd13, -1, 0, -1, 6, 12, 0, 4, 1, 0, 1);
        expect_lookup("hit_1_3",   1, 3, 8'd0,  8'd0,  8'd0,  8'd0,  -1, 0, -1, 2, 13, 0, 0, -1, 1, 1);

        // Stalled fill: 3 idle cycles between words 1 and 2
        expect_lookup("stall_miss", 2, 0, 8'd20, 8'd21, 8'd22, 8'd23, 2, 3, -1, 9, 20, 0, 7, 2, 1, 2);
        expect_lookup("hit_2_1", 2, 1, 8'd0, 8'd0, 8'd0, 8'd0, -1, 0, -1, 2, 21, 0, 0, -1, 2, 2);
        expect_lookup("hit_2_2", 2, 2, 8'd0, 8'd0, 8'd0, 8'd0, -1, 0, -1, 2, 22, 0, 0, -1, 3, 2);
        expect_lookup("hit_2_3", 2, 3, 8'd0, 8'd0, 8'd0, 8'd0, -1, 0, -1, 2, 23, 0, 0, -1, 3, 2);

        // Out-of-range indices
        expect_lookup("oor_from", 5, 0, 8'd0, 8'd0, 8'd0, 8'd0, -1, 0, -1, 1, 255, 1, 0, -1, 3, 2);
        expect_lookup("oor_to",   0, 4, 8'd0, 8'd0, 8'd0, 8'd0, -1, 0, -1, 1, 255, 1, 0, -1, 3, 2);

        // Flush in IDLE beats a simultaneous request
        flush = 1'b1; rd_valid = 1'b1; rd_from = 3'd1; rd_to = 3'd0;
        #1;
        check("flush_idle_rd_ready", 32'(rd_ready), 0);
        @(negedge clock);
        flush = 1'b0; rd_valid = 1'b0;
        #1;
        check("flush_idle_not_accepted_fill", 32'(fill_req), 0);
        check("flush_idle_ready_again", 32'(rd_ready), 1);
        @(negedge clock);
        check("flush_idle_no_resp", 32'(resp_valid), 0);
        expect_lookup("after_flush_miss", 1, 0, 8'd30, 8'd31, 8'd32, 8'd33, -1, 0, -1, 6, 30, 0, 4, 1, 3, 3);

        // Flush during fill: lookup still answered, row dropped afterwards
        expect_lookup("flush_in_fill", 3, 1, 8'd40, 8'd41, 8'd42, 8'd43, -1, 0, 1, 6, 41, 0, 4, 3, 3, 3);
        expect_lookup("refill_row3",   3, 2, 8'd50, 8'd51, 8'd52, 8'd53, -1, 0, -1, 6, 52, 0, 4, 3, 3, 3);
        expect_lookup("hit_3_3",       3, 3, 8'd0,  8'd0,  8'd0,  8'd0,  -1, 0, -1, 2, 53, 0, 0, -1, 3, 3);

        // Reset in the middle of a fill of row 0
        for (int i = 0; i < 20 && !rd_ready; i++) @(negedge clock);
        rd_valid = 1'b1; rd_from = 3'd0; rd_to = 3'd0;
        @(negedge clock);
        rd_valid = 1'b0;
        check("midfill_fill_req", 32'(fill_req), 1);
        fill_valid = 1'b1; fill_data = 8'd70;
        @(negedge clock);
        fill_data = 8'd71;
        @(negedge clock);
        fill_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_reset_state("midfill_reset");
        for (int i = 0; i < 3; i++) begin
            fill_valid = 1'b1; fill_data = 8'hEE;
            @(negedge clock);
            check("stray_fill_req", 32'(fill_req), 0);
            check("stray_resp_valid", 32'(resp_valid), 0);
        end
        fill_valid = 1'b0;

        // Row 0 must miss again; then five hits saturate the 2-bit counter
        expect_lookup("row0_miss", 0, 1, 8'd60, 8'd61, 8'd62, 8'd63, -1, 0, -1, 6, 61, 0, 4, 0, 0, 1);
        expect_lookup("sat_hit1", 0, 0, 8'd0, 8'd0, 8'd0, 8'd0, -1, 0, -1, 2, 60, 0, 0, -1, 1, 1);
        expect_lookup("sat_hit2", 0, 2, 8'd0, 8'd0, 8'd0, 8'd0, -1, 0, -1, 2, 62, 0, 0, -1, 2, 1);
        expect_lookup("sat_hit3", 0, 3, 8'd0, 8'd0, 8'd0, 8'd0, -1, 0, -1, 2, 63, 0, 0, -1, 3, 1);
        expect_lookup("sat_hit4", 0, 1, 8'd0, 8'd0, 8'd0, 8'd0, -1, 0, -1, 2, 61, 0, 0, -1, 3, 1);
        expect_lookup("sat_hit5", 0, 0, 8'd0, 8'd0, 8'd0, 8'd0, -1, 0, -1, 2, 60, 0, 0, -1, 3, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
